mem_access_unit: RTL

- Memory-stage load/store unit between the processor's M-stage outputs (address, write data, write/read strobes, funct3) and a handshaked data-memory bus.
- Computes byte enables and store-data lane replication, and drives a req/gnt/rvalid transaction.
- Aligns and sign- or zero-extends load data.
- Stalls the pipeline until the access completes; flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/load_extend.sv | 32 +++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the memory-stage load/store unit.
//   - FSM state encoding (IDLE, REQ, WAIT_R, DONE)
//   - funct3 size/sign encodings for loads and stores
//   - latched bus request record
//   - byte-enable, store-lane and alignment helpers
package lsu_pkg;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE   = 2'd0;
    localparam lsu_state_t REQ    = 2'd1;
    localparam lsu_state_t WAIT_R = 2'd2;
    localparam lsu_state_t DONE   = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Everything the bus phase needs once the pipeline inputs are released.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic [1:0]  lo;
    } mem_req_t;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b00:   be_gen = 4'b0001 << lo;
            2'b01:   be_gen = 4'b0011 << lo;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    // Replicate the store data across every lane it might land in.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   store_lanes = {4{wdata[7:0]}};
            2'b01:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    // Illegal funct3 for the direction is reported the same way as bad alignment.
    function automatic logic access_misaligned(input logic we, input logic [2:0] funct3,
                                               input logic [1:0] lo);
        logic legal;
        logic bad_align;
        if (we) legal = (funct3 inside {F3_B, F3_H, F3_W});
        else    legal = (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (funct3[1:0])
            2'b01:   bad_align = lo[0];
            2'b10:   bad_align = |lo;
            default: bad_align = 1'b0;
        endcase
        access_misaligned = !legal || bad_align;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword from a bus word and
// sign- or zero-extends it according to the load funct3.
//   word    in  32  raw bus read word
//   addr_lo in  2   byte offset of the access
//   funct3  in  3   LB/LH/LW/LBU/LHU
//   result  out 32  extended load value
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{addr_lo, 3'b000} +: 8];
        // Halfwords are always 2-byte aligned here, so addr_lo[1] picks the lane.
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_BU:   result = {24'd0, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_HU:   result = {16'd0, h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit driving a req/gnt/rvalid bus.
//   clk, rst            clock, async active-low reset
//   mem_read_m/write_m  M-stage load/store strobes (store wins)
//   addr_m, wdata_m     byte address and store data
//   funct3_m            access size/sign
//   rdata_m             extended load result (held until next load/timeout)
//   stall_m             hold F/D/E/M while an access is in flight
//   misalign_err        pulse, cycle after a rejected access
//   timeout_err         pulse, cycle after a bus timeout
//   bus_req/we/addr/be/wdata  bus request side
//   bus_gnt/rvalid/rdata      bus response side
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wdata_m,
    input  logic [2:0]        funct3_m,
    output logic [31:0]       rdata_m,
    output logic              stall_m,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    // Counter runs 0..TIMEOUT_CYCLES-1 inside one state.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    mem_req_t          req_q;
    logic              access;
    logic              misaligned;
    logic              tmo_hit;
    logic [31:0]       ext_word;

    assign access     = mem_read_m | mem_write_m;
    assign misaligned = access_misaligned(mem_write_m, funct3_m, addr_m[1:0]);
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    // Decoded from state so the async reset drops it immediately.
    assign bus_req   = (state == REQ);
    assign bus_we    = req_q.we;
    assign bus_be    = req_q.be;
    assign bus_wdata = req_q.wdata;

    load_extend u_ext (
        .word    (bus_rdata),
        .addr_lo (req_q.lo),
        .funct3  (req_q.funct3),
        .result  (ext_word)
    );

    always_comb begin
        stall_m = 1'b0;
        case (state)
            IDLE:        stall_m = access & ~misaligned;
            REQ, WAIT_R: stall_m = 1'b1;
            default:     stall_m = 1'b0;
        endcase
        // Pipeline must not be held while the unit is in reset.
        if (!rst) stall_m = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_q        <= '0;
            bus_addr     <= '0;
            rdata_m      <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            req_q.we     <= mem_write_m;
                            req_q.be     <= be_gen(funct3_m, addr_m[1:0]);
                            req_q.wdata  <= store_lanes(funct3_m, wdata_m);
                            req_q.funct3 <= funct3_m;
                            req_q.lo     <= addr_m[1:0];
                            bus_addr     <= {addr_m[ADDR_W-1:2], 2'b00};
                            cnt          <= '0;
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    // gnt on the last allowed cycle still wins over the timeout.
                    if (bus_gnt) begin
                        cnt   <= '0;
                        state <= req_q.we ? DONE : WAIT_R;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        if (!req_q.we) rdata_m <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rdata_m <= ext_word;
                        state   <= DONE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        rdata_m     <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
